// File: rtl/rp_pio_cpl_tracker_pkg.sv
// Shared types, completion status codes and SysError/Status bit positions
// for the root-port PIO completion tracker.
package rp_pio_cpl_tracker_pkg;

    typedef enum logic [1:0] {
        PIO_CFG = 2'd0,
        PIO_IO  = 2'd1,
        PIO_MEM = 2'd2
    } pio_type_e;

    typedef enum logic [1:0] {
        ERR_UR  = 2'd0,
        ERR_CA  = 2'd1,
        ERR_CTO = 2'd2
    } err_kind_e;

    localparam logic [2:0] CPL_SC = 3'b000;
    localparam logic [2:0] CPL_UR = 3'b001;
    localparam logic [2:0] CPL_CA = 3'b100;

    localparam int ERR_CFG_UR  = 0;
    localparam int ERR_CFG_CA  = 1;
    localparam int ERR_CFG_CTO = 2;
    localparam int ERR_IO_UR   = 8;
    localparam int ERR_IO_CA   = 9;
    localparam int ERR_IO_CTO  = 10;
    localparam int ERR_MEM_UR  = 16;
    localparam int ERR_MEM_CA  = 17;
    localparam int ERR_MEM_CTO = 18;

    // The reserved request type is tracked as a memory request.
    function automatic pio_type_e decode_type(logic [1:0] raw);
        return (raw == 2'd3) ? PIO_MEM : pio_type_e'(raw);
    endfunction

    function automatic logic [31:0] err_bit(pio_type_e t, err_kind_e k);
        int pos;
        case (t)
            PIO_CFG: pos = (k == ERR_UR) ? ERR_CFG_UR : (k == ERR_CA) ? ERR_CFG_CA : ERR_CFG_CTO;
            PIO_IO:  pos = (k == ERR_UR) ? ERR_IO_UR  : (k == ERR_CA) ? ERR_IO_CA  : ERR_IO_CTO;
            default: pos = (k == ERR_UR) ? ERR_MEM_UR : (k == ERR_CA) ? ERR_MEM_CA : ERR_MEM_CTO;
        endcase
        return 32'd1 << pos;
    endfunction

endpackage

// File: rtl/rp_pio_cpl_tracker_if.sv
// Request/completion/error bundle between the root-port PIO issuer (master)
// and the completion tracker (slave).
interface rp_pio_cpl_tracker_if #(
    parameter int NUM_TAGS = 8
);
    localparam int TAG_W = $clog2(NUM_TAGS);

    // A request transfers on any cycle where req_valid && req_ready; req_tag
    // names the slot it lands in. Completions have no back-pressure.
    logic             req_valid;
    logic [1:0]       req_type;
    logic             req_ready;
    logic [TAG_W-1:0] req_tag;
    logic             cpl_valid;
    logic [TAG_W-1:0] cpl_tag;
    logic [2:0]       cpl_status;
    logic             err_we;
    logic [31:0]      err_wdata;
    logic             unexp_cpl;
    logic [TAG_W:0]   outstanding;

    modport master (
        output req_valid, req_type, cpl_valid, cpl_tag, cpl_status,
        input  req_ready, req_tag, err_we, err_wdata, unexp_cpl, outstanding
    );

    modport slave (
        input  req_valid, req_type, cpl_valid, cpl_tag, cpl_status,
        output req_ready, req_tag, err_we, err_wdata, unexp_cpl, outstanding
    );

endinterface

// File: rtl/rp_pio_tag_entry.sv
// One outstanding-request slot: valid flag, request type and a saturating
// age in timeout ticks, with the timeout compare against TIMEOUT_TICKS.
module rp_pio_tag_entry
    import rp_pio_cpl_tracker_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 100
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      tick_i,
    input  logic      alloc_i,
    input  pio_type_e type_i,
    input  logic      free_i,
    output logic      valid_o,
    output pio_type_e type_o,
    output logic      timeout_o
);

    localparam logic [7:0] TMO_AGE = 8'(TIMEOUT_TICKS);

    logic      valid_q, valid_d;
    pio_type_e type_q, type_d;
    logic [7:0] age_q, age_d;

    always_comb begin
        valid_d = valid_q;
        type_d  = type_q;
        age_d   = age_q;
        if (free_i) begin
            valid_d = 1'b0;
        end else if (alloc_i) begin
            valid_d = 1'b1;
            type_d  = type_i;
            age_d   = 8'd0;
        end else if (valid_q && tick_i && (age_q != 8'hFF)) begin
            age_d = age_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            type_q  <= PIO_CFG;
            age_q   <= 8'd0;
        end else begin
            valid_q <= valid_d;
            type_q  <= type_d;
            age_q   <= age_d;
        end
    end

    assign valid_o   = valid_q;
    assign type_o    = type_q;
    assign timeout_o = valid_q && (age_q >= TMO_AGE);

endmodule

// File: rtl/rp_pio_cpl_tracker.sv
// Root-port non-posted PIO completion tracker: tag allocation, completion
// matching, completion timeout and SysError/Status error reporting.
module rp_pio_cpl_tracker
    import rp_pio_cpl_tracker_pkg::*;
#(
    parameter int NUM_TAGS      = 8,
    parameter int TICK_DIV      = 16,
    parameter int TIMEOUT_TICKS = 100
) (
    input logic                 clk,
    input logic                 rst,
    rp_pio_cpl_tracker_if.slave bus
);

    localparam int TAG_W = $clog2(NUM_TAGS);
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0]    presc_q, presc_d;
    logic                tick;

    logic [NUM_TAGS-1:0] valid_v, timeout_v, alloc_v, free_v;
    pio_type_e           type_v [NUM_TAGS];

    logic                any_free;
    logic [TAG_W-1:0]    free_tag;
    logic [TAG_W:0]      count;
    logic                accept;
    logic                cpl_hit;
    pio_type_e           req_type_dec;

    logic [31:0]         err_d, err_wdata_q;
    logic                err_we_q;
    logic                unexp_d, unexp_q;

    assign tick    = (presc_q == PRE_LAST);
    assign presc_d = tick ? '0 : presc_q + PRE_W'(1);

    // Allocation sees only registered valid bits, so a slot freed this
    // cycle becomes allocatable on the next one.
    always_comb begin
        any_free = 1'b0;
        free_tag = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!valid_v[i]) begin
                any_free = 1'b1;
                free_tag = TAG_W'(i);
            end
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            count = count + (TAG_W + 1)'(valid_v[i]);
        end
    end

    assign accept       = bus.req_valid && any_free;
    assign alloc_v      = accept ? (NUM_TAGS'(1) << free_tag) : '0;
    assign req_type_dec = decode_type(bus.req_type);
    assign cpl_hit      = bus.cpl_valid && valid_v[bus.cpl_tag];
    assign unexp_d      = bus.cpl_valid && !valid_v[bus.cpl_tag];

    // A completion landing on the same cycle as its slot's timeout wins.
    always_comb begin
        err_d  = '0;
        free_v = timeout_v;
        if (cpl_hit) begin
            free_v[bus.cpl_tag] = 1'b1;
            case (bus.cpl_status)
                CPL_SC:  ;
                CPL_UR:  err_d = err_d | err_bit(type_v[bus.cpl_tag], ERR_UR);
                CPL_CA:  err_d = err_d | err_bit(type_v[bus.cpl_tag], ERR_CA);
                default: err_d = err_d | err_bit(type_v[bus.cpl_tag], ERR_UR);
            endcase
        end
        for (int i = 0; i < NUM_TAGS; i++) begin
            if (timeout_v[i] && !(cpl_hit && (bus.cpl_tag == TAG_W'(i)))) begin
                err_d = err_d | err_bit(type_v[i], ERR_CTO);
            end
        end
    end

    for (genvar g = 0; g < NUM_TAGS; g++) begin : g_entry
        rp_pio_tag_entry #(
            .TIMEOUT_TICKS(TIMEOUT_TICKS)
        ) u_entry (
            .clk      (clk),
            .rst      (rst),
            .tick_i   (tick),
            .alloc_i  (alloc_v[g]),
            .type_i   (req_type_dec),
            .free_i   (free_v[g]),
            .valid_o  (valid_v[g]),
            .type_o   (type_v[g]),
            .timeout_o(timeout_v[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q     <= '0;
            err_we_q    <= 1'b0;
            err_wdata_q <= '0;
            unexp_q     <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            err_we_q    <= |err_d;
            err_wdata_q <= err_d;
            unexp_q     <= unexp_d;
        end
    end

    assign bus.req_ready   = any_free;
    assign bus.req_tag     = free_tag;
    assign bus.outstanding = count;
    assign bus.err_we      = err_we_q;
    assign bus.err_wdata   = err_wdata_q;
    assign bus.unexp_cpl   = unexp_q;

endmodule

// File: doc/rp_pio_cpl_tracker.md
RP_PIO_CPL_TRACKER -- requirements
Module: rp_pio_cpl_tracker

Interface
REQ-001 SHALL have parameter NUM_TAGS, default 8: outstanding non-posted PIO request slots, power of two, 2..16.
REQ-002 SHALL have parameter TICK_DIV, default 16: clk cycles per timeout tick, at least 1.
REQ-003 SHALL have parameter TIMEOUT_TICKS, default 100: ticks before completion timeout, 1..255.
REQ-004 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 req_valid  in  1  root port issues a non-posted PIO request.
REQ-008 req_type  in  2  0=CFG, 1=IO, 2=MEM; 3 is reserved.
REQ-009 req_ready  out  1  a free tag exists; the request is accepted when req_valid&&req_ready.
REQ-010 req_tag  out  clog2(NUM_TAGS)  tag assigned to the accepted request; valid while req_ready.
REQ-011 cpl_valid  in  1  completion received.
REQ-012 cpl_tag  in  clog2(NUM_TAGS)  tag of the completion.
REQ-013 cpl_status  in  3  PCIe completion status: 000=SC, 001=UR, 100=CA; any other value is treated as UR.
REQ-014 err_we  out  1  one-cycle pulse that drives the SysError/Status register write_enable.
REQ-015 err_wdata  out  32  error bits in register layout: [0]cfg_ur [1]cfg_ca [2]cfg_cto [8]io_ur [9]io_ca [10]io_cto [16]mem_ur [17]mem_ca [18]mem_cto; all other bits 0.
REQ-016 unexp_cpl  out  1  one-cycle pulse for a completion to an unallocated tag.
REQ-017 outstanding  out  clog2(NUM_TAGS)+1  count of allocated tags.

Function
REQ-018 req_ready SHALL be 1 when any tag is free, based on registered state only; req_tag SHALL be the lowest-numbered free tag.
REQ-019 On acceptance the entry SHALL store valid=1, its type, and age=0 on the next edge.
REQ-020 A request with req_type=3 SHALL be accepted and tracked as MEM.
REQ-021 A free running prescaler SHALL produce a tick every TICK_DIV cycles; on each tick, every valid entry's 8-bit age SHALL increment and saturate.
REQ-022 When an entry's age reaches TIMEOUT_TICKS the entry SHALL be freed and its type's cto bit SHALL be set.
REQ-023 A completion to a valid tag SHALL free the entry; UR and CA SHALL set the type's ur or ca bit, and SC SHALL set no bit.
REQ-024 A completion to an invalid tag SHALL produce no state change and pulse unexp_cpl one cycle later.
REQ-025 All errors detected in one cycle, including multiple timeouts, SHALL be ORed into one err_wdata word with err_we=1 on the following cycle; otherwise err_we=0 and err_wdata=0.
REQ-026 Completion and timeout for the same tag in the same cycle: completion SHALL win and no cto SHALL be flagged.
REQ-027 A tag freed in cycle N SHALL NOT be reallocated before cycle N+1.
REQ-028 Acceptance and completion in the same cycle on different tags SHALL both take effect; outstanding SHALL net to the same value.
REQ-029 Error latency: event cycle N -> err_we high in cycle N+1, never merged with N+2.

Reset
REQ-030 rst SHALL clear all entries, the prescaler, err_we, err_wdata and unexp_cpl; outstanding SHALL be 0 and req_ready SHALL be 1 in the cycle after reset.
REQ-031 rst asserted mid-operation SHALL discard outstanding requests without flagging any error.

Structure
REQ-032 A shared package SHALL hold the pio_type_e enum (CFG/IO/MEM), cpl_status constants, and err_wdata bit-position localparams shared with the SysError register.
REQ-033 The per-tag entry (valid, type, age, timeout compare) SHALL be a sub-module, rp_pio_tag_entry, instanced NUM_TAGS times; allocation, priority encode and error merge SHALL be in the top.

Verification
REQ-034 Use TICK_DIV=2 and TIMEOUT_TICKS=3: issue an IO request, send no completion -> err_we with err_wdata=0x0000_0400 about 6 cycles after acceptance; outstanding returns to 0.
REQ-035 CFG request tag 0, then completion tag 0 with status 001 -> err_wdata=0x0000_0001 one cycle later; an SC completion instead -> no err_we.
REQ-036 Fill all 8 tags -> req_ready=0; complete tag 5 -> next cycle req_ready=1 and req_tag=5.
REQ-037 Issue MEM and CFG requests in the same tick window and let both time out together -> single err_we with err_wdata=0x0004_0004.
REQ-038 Send a completion to tag 3 while it is free -> unexp_cpl pulse; err_we stays 0; completion and timeout on the same cycle -> only ur/ca/none flagged.
REQ-039 Assert rst with 4 tags outstanding -> no err_we; outstanding=0 and req_ready=1 the cycle after reset.
